// File: rtl/decode_issue_ctrl.sv
// Decode/issue control: owns the ID/EX register, forwards operands from EX/MA/WB,
// inserts bubbles on load-use and branch flush, and keeps saturating stall/flush counters.
module decode_issue_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      id_rs1_dat,
    input  logic [31:0]      id_rs2_dat,
    input  logic [31:0]      id_imm,
    input  logic             id_sel_imm,
    input  logic [31:0]      id_pc,
    input  logic             id_sel_pc,
    input  logic             if_branch_taken,
    input  logic [31:0]      if_branch_nt_pc,
    input  logic             id_fwd_we,
    input  logic [4:0]       id_fwd_dst,
    input  logic [31:0]      id_fwd_dat,
    input  logic             ma_fwd_we,
    input  logic [4:0]       ma_fwd_dst,
    input  logic [31:0]      ma_fwd_dat,
    input  logic             wb_fwd_we,
    input  logic [4:0]       wb_fwd_dst,
    input  logic [31:0]      wb_fwd_dat,
    input  logic             ex_load,
    input  logic             ex_branch_flush,
    output logic [31:0]      ex_inst,
    output logic [31:0]      ex_dat_a,
    output logic [31:0]      ex_dat_b,
    output logic [31:0]      ex_rd2,
    output logic             id_branch_taken,
    output logic [31:0]      id_branch_nt_pc,
    output logic             id_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0] BUBBLE    = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e      state_q, state_d;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, ex_rd;
    logic        rs1_used, rs2_used;
    logic        load_use;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        bubble, stall_inc, flush_inc;

    assign opcode = id_inst[6:0];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];
    assign ex_rd  = ex_inst[11:7];

    assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign rs2_used = opcode inside {OP_OP, OP_STORE, OP_BRANCH};

    // EX forwarding of a load would carry the address, not the data, hence the stall.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

    always_comb begin
        fwd_rs1 = id_rs1_dat;
        if (rs1 != 5'd0) begin
            if (id_fwd_we && (id_fwd_dst == rs1)) begin
                fwd_rs1 = id_fwd_dat;
            end else if (ma_fwd_we && (ma_fwd_dst == rs1)) begin
                fwd_rs1 = ma_fwd_dat;
            end else if (wb_fwd_we && (wb_fwd_dst == rs1)) begin
                fwd_rs1 = wb_fwd_dat;
            end
        end
    end

    always_comb begin
        fwd_rs2 = id_rs2_dat;
        if (rs2 != 5'd0) begin
            if (id_fwd_we && (id_fwd_dst == rs2)) begin
                fwd_rs2 = id_fwd_dat;
            end else if (ma_fwd_we && (ma_fwd_dst == rs2)) begin
                fwd_rs2 = ma_fwd_dat;
            end else if (wb_fwd_we && (wb_fwd_dst == rs2)) begin
                fwd_rs2 = wb_fwd_dat;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        id_stall  = 1'b0;
        bubble    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            StRun: begin
                if (ex_branch_flush) begin
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    state_d   = StStall;
                    bubble    = 1'b1;
                    id_stall  = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            StStall: begin
                // Load data is now in MA and reaches decode through ma_fwd.
                state_d = StRun;
                if (ex_branch_flush) begin
                    bubble    = 1'b1;
                    flush_inc = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            ex_inst         <= BUBBLE;
            ex_dat_a        <= 32'd0;
            ex_dat_b        <= 32'd0;
            ex_rd2          <= 32'd0;
            id_branch_taken <= 1'b0;
            id_branch_nt_pc <= 32'd0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            state_q         <= state_d;
            ex_inst         <= bubble ? BUBBLE : id_inst;
            ex_dat_a        <= id_sel_pc ? id_pc : fwd_rs1;
            ex_dat_b        <= id_sel_imm ? id_imm : fwd_rs2;
            ex_rd2          <= fwd_rs2;
            // A bubble must never look like a taken prediction to execute.
            id_branch_taken <= bubble ? 1'b0 : if_branch_taken;
            id_branch_nt_pc <= if_branch_nt_pc;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
